// File: rtl/rename_pkg.sv
// Shared definitions for the rename map table: default sizes, logical-register
// index width helper and the table's init/run state encoding.
package rename_pkg;

  localparam int LREG_N_DEF = 32;
  localparam int PREG_W_DEF = 6;

  function automatic int lreg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/rename_map_entry.sv
// One logical register of the alias table: speculative and committed preg with
// their own rename/commit priority selection and restart/init loading.
module rename_map_entry
  import rename_pkg::*;
#(
  parameter int ENTRY_ID = 0,
  parameter int LW       = lreg_width(LREG_N_DEF),
  parameter int PREG_W   = PREG_W_DEF,
  parameter int RENAME_W = 2,
  parameter int COMMIT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         restart,
  input  logic                         rename_en,
  input  logic                         commit_en,
  input  logic [RENAME_W-1:0]          regist_valid,
  input  logic [RENAME_W*LW-1:0]       regist_lreg,
  input  logic [RENAME_W*PREG_W-1:0]   regist_preg,
  input  logic [COMMIT_W-1:0]          commit_valid,
  input  logic [COMMIT_W*LW-1:0]       commit_lreg,
  input  logic [COMMIT_W*PREG_W-1:0]   commit_preg,
  output logic [PREG_W-1:0]            spec_preg
);

  localparam logic [LW-1:0]     MY_LREG   = LW'(ENTRY_ID);
  localparam logic [PREG_W-1:0] IDENT_PREG = PREG_W'(ENTRY_ID);

  logic [PREG_W-1:0] spec_q, spec_d;
  logic [PREG_W-1:0] comm_q, comm_d;
  logic [PREG_W-1:0] comm_merged;
  logic [PREG_W-1:0] rename_val;

  always_comb begin
    // Ascending scans let the highest matching slot override earlier ones.
    comm_merged = comm_q;
    for (int j = 0; j < COMMIT_W; j++) begin
      if (commit_valid[j] && (commit_lreg[j*LW +: LW] == MY_LREG))
        comm_merged = commit_preg[j*PREG_W +: PREG_W];
    end
    rename_val = spec_q;
    for (int k = 0; k < RENAME_W; k++) begin
      if (regist_valid[k] && (regist_lreg[k*LW +: LW] == MY_LREG))
        rename_val = regist_preg[k*PREG_W +: PREG_W];
    end

    spec_d = spec_q;
    comm_d = comm_q;
    if (init) begin
      spec_d = IDENT_PREG;
      comm_d = IDENT_PREG;
    end else begin
      if (commit_en) comm_d = comm_merged;
      if (restart)        spec_d = comm_merged;
      else if (rename_en) spec_d = rename_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_q <= '0;
      comm_q <= '0;
    end else begin
      spec_q <= spec_d;
      comm_q <= comm_d;
    end
  end

  assign spec_preg = spec_q;

endmodule

// File: rtl/rename_map_table.sv
// Speculative register alias table: init/run control, per-entry storage,
// combinational source/old-preg reads with intra-group bypass.
module rename_map_table
  import rename_pkg::*;
#(
  parameter int  LREG_N   = LREG_N_DEF,
  parameter int  PREG_W   = PREG_W_DEF,
  parameter int  RENAME_W = 2,
  parameter int  COMMIT_W = 4,
  localparam int LW       = lreg_width(LREG_N)
) (
  input  logic                           iCLOCK,
  input  logic                           iRESET,
  output logic                           oREADY,
  input  logic                           iRESTART_VALID,
  input  logic                           iLOCK,
  input  logic [RENAME_W-1:0]            iREGIST_VALID,
  input  logic [RENAME_W*LW-1:0]         iREGIST_LREG,
  input  logic [RENAME_W*PREG_W-1:0]     iREGIST_PREG,
  input  logic [RENAME_W*2*LW-1:0]       iSRC_LREG,
  output logic [RENAME_W*2*PREG_W-1:0]   oSRC_PREG,
  output logic [RENAME_W*PREG_W-1:0]     oOLD_PREG,
  input  logic [COMMIT_W-1:0]            iCOMMIT_VALID,
  input  logic [COMMIT_W*LW-1:0]         iCOMMIT_LREG,
  input  logic [COMMIT_W*PREG_W-1:0]     iCOMMIT_PREG
);

  state_t state_q, state_d;
  logic   run, init, rename_en, restart;
  logic [PREG_W-1:0] spec_map [0:LREG_N-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  assign run       = (state_q == ST_RUN);
  assign init      = (state_q == ST_INIT);
  assign restart   = run && iRESTART_VALID;
  assign rename_en = run && !iLOCK && !iRESTART_VALID;
  assign oREADY    = run;

  for (genvar gi = 0; gi < LREG_N; gi++) begin : g_entry
    rename_map_entry #(
      .ENTRY_ID (gi),
      .LW       (LW),
      .PREG_W   (PREG_W),
      .RENAME_W (RENAME_W),
      .COMMIT_W (COMMIT_W)
    ) u_entry (
      .clk          (iCLOCK),
      .rst          (iRESET),
      .init         (init),
      .restart      (restart),
      .rename_en    (rename_en),
      .commit_en    (run),
      .regist_valid (iREGIST_VALID),
      .regist_lreg  (iREGIST_LREG),
      .regist_preg  (iREGIST_PREG),
      .commit_valid (iCOMMIT_VALID),
      .commit_lreg  (iCOMMIT_LREG),
      .commit_preg  (iCOMMIT_PREG),
      .spec_preg    (spec_map[gi])
    );
  end

  function automatic logic in_range(input logic [LW-1:0] l);
    return int'(l) < LREG_N;
  endfunction

  // Map lookup plus bypass from the youngest older slot renaming the same lreg;
  // bypass is held off until the table is running so reset/init reads stay 0.
  function automatic logic [PREG_W-1:0] lookup(input int k, input logic [LW-1:0] l);
    logic [PREG_W-1:0] v;
    v = in_range(l) ? spec_map[l] : '0;
    for (int m = 0; m < k; m++) begin
      if (run && in_range(l) && iREGIST_VALID[m] && (iREGIST_LREG[m*LW +: LW] == l))
        v = iREGIST_PREG[m*PREG_W +: PREG_W];
    end
    return v;
  endfunction

  always_comb begin
    oSRC_PREG = '0;
    oOLD_PREG = '0;
    for (int k = 0; k < RENAME_W; k++) begin
      for (int s = 0; s < 2; s++)
        oSRC_PREG[(2*k+s)*PREG_W +: PREG_W] = lookup(k, iSRC_LREG[(2*k+s)*LW +: LW]);
      oOLD_PREG[k*PREG_W +: PREG_W] = lookup(k, iREGIST_LREG[k*LW +: LW]);
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus randomized
// traffic compared with a per-cycle behavioural model of both maps.
module tb_rename_map_table;

  localparam int LW = 5;
  localparam int PW = 6;

  logic iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  logic         iRESET;
  logic         oREADY;
  logic         iRESTART_VALID;
  logic         iLOCK;
  logic [1:0]   iREGIST_VALID;
  logic [9:0]   iREGIST_LREG;
  logic [11:0]  iREGIST_PREG;
  logic [19:0]  iSRC_LREG;
  logic [23:0]  oSRC_PREG;
  logic [11:0]  oOLD_PREG;
  logic [3:0]   iCOMMIT_VALID;
  logic [19:0]  iCOMMIT_LREG;
  logic [23:0]  iCOMMIT_PREG;

  logic          r_valid [2];
  logic [LW-1:0] r_lreg  [2];
  logic [PW-1:0] r_preg  [2];
  logic [LW-1:0] s_lreg  [2][2];
  logic          c_valid [4];
  logic [LW-1:0] c_lreg  [4];
  logic [PW-1:0] c_preg  [4];

  logic [PW-1:0] m_spec [32];
  logic [PW-1:0] m_comm [32];
  logic          m_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always_comb begin
    iREGIST_VALID = '0;
    iREGIST_LREG  = '0;
    iREGIST_PREG  = '0;
    iSRC_LREG     = '0;
    iCOMMIT_VALID = '0;
    iCOMMIT_LREG  = '0;
    iCOMMIT_PREG  = '0;
    for (int k = 0; k < 2; k++) begin
      iREGIST_VALID[k]           = r_valid[k];
      iREGIST_LREG[k*LW +: LW]   = r_lreg[k];
      iREGIST_PREG[k*PW +: PW]   = r_preg[k];
      for (int s = 0; s < 2; s++)
        iSRC_LREG[(2*k+s)*LW +: LW] = s_lreg[k][s];
    end
    for (int j = 0; j < 4; j++) begin
      iCOMMIT_VALID[j]         = c_valid[j];
      iCOMMIT_LREG[j*LW +: LW] = c_lreg[j];
      iCOMMIT_PREG[j*PW +: PW] = c_preg[j];
    end
  end

  rename_map_table dut (
    .iCLOCK         (iCLOCK),
    .iRESET         (iRESET),
    .oREADY         (oREADY),
    .iRESTART_VALID (iRESTART_VALID),
    .iLOCK          (iLOCK),
    .iREGIST_VALID  (iREGIST_VALID),
    .iREGIST_LREG   (iREGIST_LREG),
    .iREGIST_PREG   (iREGIST_PREG),
    .iSRC_LREG      (iSRC_LREG),
    .oSRC_PREG      (oSRC_PREG),
    .oOLD_PREG      (oOLD_PREG),
    .iCOMMIT_VALID  (iCOMMIT_VALID),
    .iCOMMIT_LREG   (iCOMMIT_LREG),
    .iCOMMIT_PREG   (iCOMMIT_PREG)
  );

  function automatic logic [PW-1:0] src_out(input int k, input int s);
    return oSRC_PREG[(2*k+s)*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] old_out(input int k);
    return oOLD_PREG[k*PW +: PW];
  endfunction

  // Expected read: the youngest older slot in this group naming l, else the map.
  function automatic logic [PW-1:0] exp_read(input int k, input logic [LW-1:0] l);
    if (!m_ready) return '0;
    for (int m = k - 1; m >= 0; m--)
      if (r_valid[m] && r_lreg[m] == l) return r_preg[m];
    return m_spec[l];
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = '0;
      m_comm[i] = '0;
    end
    m_ready = 1'b0;
  endtask

  task automatic model_update();
    logic [PW-1:0] nc [32];
    if (iRESET) begin
      model_zero();
    end else if (!m_ready) begin
      for (int i = 0; i < 32; i++) begin
        m_spec[i] = PW'(i);
        m_comm[i] = PW'(i);
      end
      m_ready = 1'b1;
    end else begin
      nc = m_comm;
      for (int j = 0; j < 4; j++)
        if (c_valid[j]) nc[c_lreg[j]] = c_preg[j];
      if (iRESTART_VALID) m_spec = nc;
      else if (!iLOCK)
        for (int k = 0; k < 2; k++)
          if (r_valid[k]) m_spec[r_lreg[k]] = r_preg[k];
      m_comm = nc;
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    model_update();
    @(negedge iCLOCK);
  endtask

  task automatic clr();
    iRESTART_VALID = 1'b0;
    iLOCK          = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_valid[k] = 1'b0;
      r_lreg[k]  = '0;
      r_preg[k]  = '0;
      s_lreg[k][0] = '0;
      s_lreg[k][1] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      c_valid[j] = 1'b0;
      c_lreg[j]  = '0;
      c_preg[j]  = '0;
    end
  endtask

  task automatic set_read(input logic [LW-1:0] a, input logic [LW-1:0] b);
    s_lreg[0][0] = a;
    s_lreg[0][1] = b;
  endtask

  task automatic test_reset();
    iRESET = 1'b1;
    model_zero();
    clr();
    set_read(5'd7, 5'd31);
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    #1;
    n_checks++; if (oREADY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b want=0", oREADY); end
    n_checks++; if (src_out(0, 0) !== 6'd0) begin n_fail++; $display("FAIL reset_src got=%0d want=0", src_out(0, 0)); end
    iRESET = 1'b0;
    #1;
    n_checks++; if (oREADY !== 1'b0) begin n_fail++; $display("FAIL init_ready got=%0b want=0", oREADY); end
    tick();
    #1;
    n_checks++; if (oREADY !== 1'b1) begin n_fail++; $display("FAIL run_ready got=%0b want=1", oREADY); end
    n_checks++; if (src_out(0, 0) !== 6'd7) begin n_fail++; $display("FAIL ident_r7 got=%0d want=7", src_out(0, 0)); end
    n_checks++; if (src_out(0, 1) !== 6'd31) begin n_fail++; $display("FAIL ident_r31 got=%0d want=31", src_out(0, 1)); end
    $display("test_reset: ready=%0b r7=%0d r31=%0d", oREADY, src_out(0, 0), src_out(0, 1));
  endtask

  task automatic test_bypass();
    clr();
    r_valid[0] = 1'b1; r_lreg[0] = 5'd3; r_preg[0] = 6'd40;
    r_valid[1] = 1'b1; r_lreg[1] = 5'd3; r_preg[1] = 6'd45;
    s_lreg[0][0] = 5'd3; s_lreg[1][0] = 5'd3; s_lreg[1][1] = 5'd4;
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd3) begin n_fail++; $display("FAIL slot0_no_bypass got=%0d want=3", src_out(0, 0)); end
    n_checks++; if (src_out(1, 0) !== 6'd40) begin n_fail++; $display("FAIL slot1_src_bypass got=%0d want=40", src_out(1, 0)); end
    n_checks++; if (src_out(1, 1) !== 6'd4) begin n_fail++; $display("FAIL slot1_src_map got=%0d want=4", src_out(1, 1)); end
    n_checks++; if (old_out(0) !== 6'd3) begin n_fail++; $display("FAIL slot0_old got=%0d want=3", old_out(0)); end
    n_checks++; if (old_out(1) !== 6'd40) begin n_fail++; $display("FAIL slot1_old_bypass got=%0d want=40", old_out(1)); end
    tick();
    clr();
    set_read(5'd3, 5'd4);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd45) begin n_fail++; $display("FAIL r3_after_write got=%0d want=45", src_out(0, 0)); end
    $display("test_bypass: r3 now %0d", src_out(0, 0));
  endtask

  task automatic test_lock();
    clr();
    iLOCK = 1'b1;
    r_valid[0] = 1'b1; r_lreg[0] = 5'd5; r_preg[0] = 6'd50;
    tick();
    clr();
    set_read(5'd5, 5'd0);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd5) begin n_fail++; $display("FAIL lock_holds got=%0d want=5", src_out(0, 0)); end
    r_valid[0] = 1'b1; r_lreg[0] = 5'd5; r_preg[0] = 6'd50;
    tick();
    clr();
    set_read(5'd5, 5'd0);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd50) begin n_fail++; $display("FAIL unlock_writes got=%0d want=50", src_out(0, 0)); end
    $display("test_lock: r5 now %0d", src_out(0, 0));
  endtask

  task automatic test_restart();
    clr();
    r_valid[0] = 1'b1; r_lreg[0] = 5'd2; r_preg[0] = 6'd33;
    tick();
    r_preg[0] = 6'd34;
    tick();
    clr();
    c_valid[0] = 1'b1; c_lreg[0] = 5'd2; c_preg[0] = 6'd33;
    tick();
    clr();
    iRESTART_VALID = 1'b1;
    tick();
    clr();
    set_read(5'd2, 5'd5);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd33) begin n_fail++; $display("FAIL restart_r2 got=%0d want=33", src_out(0, 0)); end
    n_checks++; if (src_out(0, 1) !== 6'd5) begin n_fail++; $display("FAIL restart_r5 got=%0d want=5", src_out(0, 1)); end
    r_valid[0] = 1'b1; r_lreg[0] = 5'd2; r_preg[0] = 6'd35;
    tick();
    clr();
    iRESTART_VALID = 1'b1;
    c_valid[0] = 1'b1; c_lreg[0] = 5'd2; c_preg[0] = 6'd34;
    tick();
    clr();
    set_read(5'd2, 5'd0);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd34) begin n_fail++; $display("FAIL restart_merge_r2 got=%0d want=34", src_out(0, 0)); end
    $display("test_restart: r2 now %0d", src_out(0, 0));
  endtask

  task automatic test_commit_restart();
    clr();
    for (int j = 0; j < 4; j++) begin
      c_valid[j] = 1'b1;
      c_lreg[j]  = 5'd9;
      c_preg[j]  = PW'(41 + j);
    end
    iRESTART_VALID = 1'b1;
    r_valid[0] = 1'b1; r_lreg[0] = 5'd10; r_preg[0] = 6'd20;
    tick();
    clr();
    set_read(5'd9, 5'd10);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd44) begin n_fail++; $display("FAIL commit_prio_r9 got=%0d want=44", src_out(0, 0)); end
    n_checks++; if (src_out(0, 1) !== 6'd10) begin n_fail++; $display("FAIL restart_drops_rename got=%0d want=10", src_out(0, 1)); end
    $display("test_commit_restart: r9=%0d r10=%0d", src_out(0, 0), src_out(0, 1));
  endtask

  task automatic test_midreset();
    clr();
    r_valid[0] = 1'b1; r_lreg[0] = 5'd1; r_preg[0] = 6'd60;
    tick();
    clr();
    set_read(5'd1, 5'd0);
    #1;
    n_checks++; if (src_out(0, 0) !== 6'd60) begin n_fail++; $display("FAIL pre_reset_r1 got=%0d want=60", src_out(0, 0)); end
    iRESET = 1'b1;
    model_zero();
    #1;
    n_checks++; if (oREADY !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready got=%0b want=0", oREADY); end
    n_checks++; if (src_out(0, 0) !== 6'd0) begin n_fail++; $display("FAIL async_reset_r1 got=%0d want=0", src_out(0, 0)); end
    tick();
    iRESET = 1'b0;
    #1;
    n_checks++; if (oREADY !== 1'b0) begin n_fail++; $display("FAIL midreset_init got=%0b want=0", oREADY); end
    tick();
    #1;
    n_checks++; if (oREADY !== 1'b1) begin n_fail++; $display("FAIL midreset_run got=%0b want=1", oREADY); end
    n_checks++; if (src_out(0, 0) !== 6'd1) begin n_fail++; $display("FAIL midreset_r1 got=%0d want=1", src_out(0, 0)); end
    $display("test_midreset: ready=%0b r1=%0d", oREADY, src_out(0, 0));
  endtask

  task automatic test_random();
    logic [PW-1:0] e;
    for (int c = 0; c < 200; c++) begin
      clr();
      iLOCK          = ($urandom_range(0, 3) == 0);
      iRESTART_VALID = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 2; k++) begin
        r_valid[k] = m_ready && ($urandom_range(0, 1) == 1);
        r_lreg[k]  = LW'($urandom_range(0, 7));
        r_preg[k]  = PW'($urandom_range(0, 63));
        s_lreg[k][0] = LW'($urandom_range(0, 7));
        s_lreg[k][1] = LW'($urandom_range(0, 31));
      end
      for (int j = 0; j < 4; j++) begin
        c_valid[j] = ($urandom_range(0, 2) == 0);
        c_lreg[j]  = LW'($urandom_range(0, 7));
        c_preg[j]  = PW'($urandom_range(0, 63));
      end
      #1;
      n_checks++; if (oREADY !== m_ready) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%0b want=%0b", c, oREADY, m_ready); end
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 2; s++) begin
          e = exp_read(k, s_lreg[k][s]);
          n_checks++;
          if (src_out(k, s) !== e) begin
            n_fail++;
            $display("FAIL rand_src cyc=%0d slot=%0d src=%0d lreg=%0d got=%0d want=%0d", c, k, s, s_lreg[k][s], src_out(k, s), e);
          end
        end
        e = exp_read(k, r_lreg[k]);
        n_checks++;
        if (old_out(k) !== e) begin
          n_fail++;
          $display("FAIL rand_old cyc=%0d slot=%0d lreg=%0d got=%0d want=%0d", c, k, r_lreg[k], old_out(k), e);
        end
      end
      $display("rand cyc=%0d lock=%0b restart=%0b rv=%0b%0b cv=%0b%0b%0b%0b", c, iLOCK, iRESTART_VALID,
               r_valid[1], r_valid[0], c_valid[3], c_valid[2], c_valid[1], c_valid[0]);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_lock();
    test_restart();
    test_commit_restart();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
